// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with flush; used for the instruction/PC buffer and the pending-PC queue.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Qualify push/pop against occupancy; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        do_pop  = pop & (count != '0);
        do_push = push & ((count != FULL) | do_pop);
        head    = mem[rd_ptr];
    end

    // Storage, pointers and occupancy; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: issues word-aligned requests, buffers in-order responses with their PCs,
// and presents them to decode; redirects flush the buffer and discard stale responses.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        exec_ftch_redirect,
    input  logic [31:0] exec_ftch_target,
    input  logic        dec_ftch_stall,
    output logic        ftch_dec_valid,
    output logic [31:0] ftch_dec_instr,
    output logic [31:0] ftch_dec_pc
);

    localparam int              CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW+1:0]   DEPTH_W = (CW + 2)'(FIFO_DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   last_pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [CW+1:0] occupancy;
    logic [31:0]   pend_head;
    logic          grant;
    logic          pop;
    logic          push;
    logic          drop_rsp;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    // Request issue, response routing and decode-side presentation.
    always_comb begin
        if ((fifo_count != '0) && !exec_ftch_redirect) begin
            ftch_dec_valid = 1'b1;
            ftch_dec_instr = head.instr;
        end else begin
            ftch_dec_valid = 1'b0;
            ftch_dec_instr = INSTR_NOP;
        end
        ftch_dec_pc = (fifo_count != '0) ? head.pc : last_pc;
        pop         = ftch_dec_valid & ~dec_ftch_stall;

        // Every granted-but-unanswered request has a reserved buffer slot.
        occupancy  = {2'b00, outstanding} + {2'b00, fifo_count} - {{(CW + 1){1'b0}}, pop};
        imem_req   = rst_n & ~exec_ftch_redirect & (occupancy < DEPTH_W);
        imem_addr  = pc_q;
        grant      = imem_req & imem_gnt;

        drop_rsp         = imem_rvalid & (exec_ftch_redirect | (drop_cnt != '0));
        push             = imem_rvalid & ~drop_rsp;
        push_entry.pc    = pend_head;
        push_entry.instr = imem_rdata;
    end

    // Fetch PC, stale-response drop counter and the PC held while the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            drop_cnt <= '0;
            last_pc  <= RESET_PC;
        end else begin
            if (exec_ftch_redirect) begin
                pc_q <= align_word(exec_ftch_target);
            end else if (grant) begin
                pc_q <= pc_q + 32'd4;
            end else begin
                pc_q <= pc_q;
            end

            if (exec_ftch_redirect) begin
                drop_cnt <= outstanding - CW'(imem_rvalid);
            end else if (imem_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end else begin
                drop_cnt <= drop_cnt;
            end

            if (fifo_count != '0) begin
                last_pc <= head.pc;
            end else begin
                last_pc <= last_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (exec_ftch_redirect),
        .head      (head),
        .count     (fifo_count)
    );

    // Its occupancy is the outstanding-request count; every response pops it, stale or not.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [31:0])
    ) u_pend (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (pc_q),
        .pop       (imem_rvalid),
        .flush     (1'b0),
        .head      (pend_head),
        .count     (outstanding)
    );

endmodule
